// File: rtl/edp_diag_snap_if.sv
// edp_diag_snap_if
// Word channel from the diagnostic snapshot sequencer to the front end.
// The snapshot block drives a single-entry valid/ready slot.
//   wordValid  : wordData/wordSel/wordParity hold a captured word
//   wordReady  : front end accepts the word on this edge
//   wordData   : captured 36-bit EBUS word, bit 0 = MSB
//   wordSel    : diag source index the word came from
//   wordParity : odd parity over wordData
interface edp_diag_snap_if;
  logic        wordValid;
  logic        wordReady;
  logic [0:35] wordData;
  logic [2:0]  wordSel;
  logic        wordParity;

  modport master (
    output wordValid, wordData, wordSel, wordParity,
    input  wordReady
  );

  modport slave (
    input  wordValid, wordData, wordSel, wordParity,
    output wordReady
  );
endinterface

// File: rtl/edp_diag_snap.sv
// edp_diag_snap
// Walks a mask of the eight EDP diagnostic sources (AR, BR, MQ, FM, BRX,
// ARX, ADX, AD) in ascending index order. For each selected source it drives
// diagSel and diagReadFunc12X, holds for SETTLE cycles, then captures the
// EBUS word with odd parity into the word slot.
// Ports:
//   clk, resetN      : clock, asynchronous active-low reset
//   start, selMask   : begin a snapshot of the masked sources (idle only)
//   abort            : terminate snapshot, drop any pending word
//   EBUS             : diag mux data from the data path, bit 0 = MSB
//   diagSel          : diag source select to the data path
//   diagReadFunc12X  : data path EBUS drive enable
//   busy             : snapshot in progress
//   done             : one-cycle pulse when a snapshot completes
//   word             : valid/ready word slot to the front end
//
// state    | meaning
// S_IDLE   | no snapshot; waiting for start
// S_SETTLE | diagSel driven, counting down the settle interval
// S_WAIT   | settled, word slot still full; holding diagSel until it drains
module edp_diag_snap #(
  parameter int unsigned SETTLE = 2
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        start,
  input  logic [7:0]  selMask,
  input  logic        abort,
  input  logic [0:35] EBUS,
  output logic [2:0]  diagSel,
  output logic        diagReadFunc12X,
  output logic        busy,
  output logic        done,
  edp_diag_snap_if.master word
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [7:0]  mask_q;
  logic [2:0]  diag_sel_q;
  logic        read_func_q;
  logic        busy_q;
  logic        done_q;
  logic        word_valid_q;
  logic [0:35] word_data_q;
  logic [2:0]  word_sel_q;
  logic        word_parity_q;

  logic        slot_free;
  logic        capture;
  logic [7:0]  mask_rem;

  function automatic logic [2:0] lowest_idx(input logic [7:0] m);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  always_comb begin
    // Slot is free if empty or being drained on this same edge.
    slot_free = ~word_valid_q | word.wordReady;
    capture   = ~abort & slot_free &
                (((state_q == S_SETTLE) && (cnt_q == 4'd0)) || (state_q == S_WAIT));
    mask_rem  = mask_q & ~(8'b1 << diag_sel_q);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= S_IDLE;
      cnt_q         <= 4'd0;
      mask_q        <= 8'd0;
      diag_sel_q    <= 3'd0;
      read_func_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      word_valid_q  <= 1'b0;
      word_data_q   <= '0;
      word_sel_q    <= 3'd0;
      word_parity_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        state_q      <= S_IDLE;
        cnt_q        <= 4'd0;
        mask_q       <= 8'd0;
        read_func_q  <= 1'b0;
        busy_q       <= 1'b0;
        word_valid_q <= 1'b0;
      end else begin
        if (capture) begin
          word_valid_q  <= 1'b1;
          word_data_q   <= EBUS;
          word_sel_q    <= diag_sel_q;
          word_parity_q <= ~^EBUS;
        end else if (word.wordReady) begin
          word_valid_q  <= 1'b0;
        end

        case (state_q)
          S_IDLE: begin
            if (start) begin
              if (selMask == 8'd0) begin
                done_q <= 1'b1;
              end else begin
                mask_q      <= selMask;
                diag_sel_q  <= lowest_idx(selMask);
                read_func_q <= 1'b1;
                busy_q      <= 1'b1;
                cnt_q       <= CNT_LOAD;
                state_q     <= S_SETTLE;
              end
            end
          end
          S_SETTLE, S_WAIT: begin
            if ((state_q == S_SETTLE) && (cnt_q != 4'd0)) begin
              cnt_q <= cnt_q - 4'd1;
            end else if (capture) begin
              mask_q <= mask_rem;
              if (mask_rem != 8'd0) begin
                diag_sel_q <= lowest_idx(mask_rem);
                cnt_q      <= CNT_LOAD;
                state_q    <= S_SETTLE;
              end else begin
                read_func_q <= 1'b0;
                busy_q      <= 1'b0;
                done_q      <= 1'b1;
                state_q     <= S_IDLE;
              end
            end else begin
              state_q <= S_WAIT;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign diagSel         = diag_sel_q;
  assign diagReadFunc12X = read_func_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign word.wordValid  = word_valid_q;
  assign word.wordData   = word_data_q;
  assign word.wordSel    = word_sel_q;
  assign word.wordParity = word_parity_q;

endmodule

// File: tb/tb_edp_diag_snap.sv
module tb_edp_diag_snap;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        start1, start2, start3;
  logic [7:0]  selMask;
  logic        abort;
  logic [0:35] EBUS;

  logic [2:0]  ds1, ds2, ds3;
  logic        rf1, rf2, rf3;
  logic        busy1, busy2, busy3;
  logic        done1, done2, done3;

  int n_chk = 0;
  int n_fail = 0;

  edp_diag_snap_if w1 ();
  edp_diag_snap_if w2 ();
  edp_diag_snap_if w3 ();

  edp_diag_snap #(.SETTLE(1)) u1 (
    .clk(clk), .resetN(resetN), .start(start1), .selMask(selMask), .abort(abort),
    .EBUS(EBUS), .diagSel(ds1), .diagReadFunc12X(rf1), .busy(busy1), .done(done1),
    .word(w1)
  );
  edp_diag_snap #(.SETTLE(2)) u2 (
    .clk(clk), .resetN(resetN), .start(start2), .selMask(selMask), .abort(abort),
    .EBUS(EBUS), .diagSel(ds2), .diagReadFunc12X(rf2), .busy(busy2), .done(done2),
    .word(w2)
  );
  edp_diag_snap #(.SETTLE(3)) u3 (
    .clk(clk), .resetN(resetN), .start(start3), .selMask(selMask), .abort(abort),
    .EBUS(EBUS), .diagSel(ds3), .diagReadFunc12X(rf3), .busy(busy3), .done(done3),
    .word(w3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [35:0] rep3(input int v);
    logic [2:0] t;
    t = 3'(v);
    return {12{t}};
  endfunction

  task automatic chk_u2_zero(input string tag);
    chk({tag, " diagSel"}, 64'(ds2), 64'd0);
    chk({tag, " readFunc"}, 64'(rf2), 64'd0);
    chk({tag, " busy"}, 64'(busy2), 64'd0);
    chk({tag, " done"}, 64'(done2), 64'd0);
    chk({tag, " wordValid"}, 64'(w2.wordValid), 64'd0);
    chk({tag, " wordData"}, 64'(w2.wordData), 64'd0);
    chk({tag, " wordSel"}, 64'(w2.wordSel), 64'd0);
    chk({tag, " wordParity"}, 64'(w2.wordParity), 64'd0);
  endtask

  initial begin
    int e[4];
    e = '{0, 2, 5, 7};
    start1 = 1'b0; start2 = 1'b0; start3 = 1'b0;
    selMask = 8'h00; abort = 1'b0; EBUS = '0;
    w1.wordReady = 1'b1; w2.wordReady = 1'b1; w3.wordReady = 1'b1;

    // Power-on reset state
    #12;
    chk_u2_zero("por");
    @(negedge clk) resetN = 1'b1;
    tick(); tick();

    // Single source, SETTLE=2
    EBUS = 36'h123456789; selMask = 8'h01; start2 = 1'b1;
    tick();  // E0
    start2 = 1'b0; selMask = 8'h00;
    chk("one busy E0", 64'(busy2), 64'd1);
    chk("one rf E0", 64'(rf2), 64'd1);
    chk("one diagSel E0", 64'(ds2), 64'd0);
    chk("one valid E0", 64'(w2.wordValid), 64'd0);
    tick();  // E1
    chk("one valid E1", 64'(w2.wordValid), 64'd0);
    chk("one busy E1", 64'(busy2), 64'd1);
    tick();  // E2
    chk("one valid E2", 64'(w2.wordValid), 64'd1);
    chk("one data E2", 64'(w2.wordData), 64'h123456789);
    chk("one sel E2", 64'(w2.wordSel), 64'd0);
    chk("one parity E2", 64'(w2.wordParity), 64'd0);
    chk("one done E2", 64'(done2), 64'd1);
    chk("one busy E2", 64'(busy2), 64'd0);
    chk("one rf E2", 64'(rf2), 64'd0);
    tick();  // E3
    chk("one done E3", 64'(done2), 64'd0);
    chk("one drained E3", 64'(w2.wordValid), 64'd0);

    // Sparse mask, SETTLE=1, free flowing
    EBUS = rep3(0); selMask = 8'hA5; start1 = 1'b1;
    tick();  // E0
    start1 = 1'b0; selMask = 8'h00;
    chk("a5 diagSel E0", 64'(ds1), 64'd0);
    chk("a5 busy E0", 64'(busy1), 64'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("a5 valid", 64'(w1.wordValid), 64'd1);
      chk("a5 sel", 64'(w1.wordSel), 64'(e[k]));
      chk("a5 data", 64'(w1.wordData), 64'(rep3(e[k])));
      chk("a5 parity", 64'(w1.wordParity), 64'd1);
      chk("a5 done", 64'(done1), 64'(k == 3));
      if (k < 3) begin
        chk("a5 next diagSel", 64'(ds1), 64'(e[k+1]));
        EBUS = rep3(e[k+1]);
      end
    end
    tick();
    chk("a5 done after", 64'(done1), 64'd0);
    chk("a5 busy after", 64'(busy1), 64'd0);

    // Backpressure, SETTLE=2, mask 03
    w2.wordReady = 1'b0;
    EBUS = 36'hABCDE1234; selMask = 8'h03; start2 = 1'b1;
    tick();  // E0
    start2 = 1'b0; selMask = 8'h00;
    tick();  // E1
    tick();  // E2
    chk("bp valid E2", 64'(w2.wordValid), 64'd1);
    chk("bp sel E2", 64'(w2.wordSel), 64'd0);
    chk("bp data E2", 64'(w2.wordData), 64'hABCDE1234);
    chk("bp diagSel E2", 64'(ds2), 64'd1);
    EBUS = 36'h0FEDCBA98;
    for (int i = 3; i <= 5; i++) begin
      tick();
      chk("bp hold valid", 64'(w2.wordValid), 64'd1);
      chk("bp hold sel", 64'(w2.wordSel), 64'd0);
      chk("bp hold data", 64'(w2.wordData), 64'hABCDE1234);
      chk("bp hold diagSel", 64'(ds2), 64'd1);
      chk("bp hold busy", 64'(busy2), 64'd1);
      chk("bp hold done", 64'(done2), 64'd0);
    end
    w2.wordReady = 1'b1;
    tick();  // E6
    chk("bp valid E6", 64'(w2.wordValid), 64'd1);
    chk("bp sel E6", 64'(w2.wordSel), 64'd1);
    chk("bp data E6", 64'(w2.wordData), 64'h0FEDCBA98);
    chk("bp done E6", 64'(done2), 64'd1);
    chk("bp busy E6", 64'(busy2), 64'd0);
    tick();
    chk("bp drained", 64'(w2.wordValid), 64'd0);

    // Abort mid-snapshot, SETTLE=3
    selMask = 8'hFF; start3 = 1'b1;
    tick();  // E0
    start3 = 1'b0; selMask = 8'h00;
    tick(); tick();  // E2
    chk("abort busy E2", 64'(busy3), 64'd1);
    abort = 1'b1;
    tick();  // E3
    abort = 1'b0;
    chk("abort busy E3", 64'(busy3), 64'd0);
    chk("abort rf E3", 64'(rf3), 64'd0);
    chk("abort valid E3", 64'(w3.wordValid), 64'd0);
    chk("abort done E3", 64'(done3), 64'd0);
    tick();
    chk("abort done E4", 64'(done3), 64'd0);
    chk("abort valid E4", 64'(w3.wordValid), 64'd0);
    chk("abort busy E4", 64'(busy3), 64'd0);

    // start and abort together in idle
    selMask = 8'hFF; start3 = 1'b1; abort = 1'b1;
    tick();
    start3 = 1'b0; abort = 1'b0; selMask = 8'h00;
    chk("sa busy", 64'(busy3), 64'd0);
    chk("sa rf", 64'(rf3), 64'd0);
    chk("sa done", 64'(done3), 64'd0);
    tick();
    chk("sa busy later", 64'(busy3), 64'd0);
    chk("sa valid later", 64'(w3.wordValid), 64'd0);

    // abort drops a pending word
    w3.wordReady = 1'b0; selMask = 8'h01; start3 = 1'b1;
    tick();  // E0
    start3 = 1'b0; selMask = 8'h00;
    tick(); tick(); tick();  // E3
    chk("abdrop valid", 64'(w3.wordValid), 64'd1);
    chk("abdrop done", 64'(done3), 64'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abdrop cleared", 64'(w3.wordValid), 64'd0);
    w3.wordReady = 1'b1;

    // start while busy is ignored
    selMask = 8'h01; start2 = 1'b1;
    tick();  // E0
    selMask = 8'hFF;  // second start presented at E1
    tick();  // E1
    start2 = 1'b0; selMask = 8'h00;
    tick();  // E2
    chk("sb valid E2", 64'(w2.wordValid), 64'd1);
    chk("sb sel E2", 64'(w2.wordSel), 64'd0);
    chk("sb done E2", 64'(done2), 64'd1);
    tick();
    chk("sb busy E3", 64'(busy2), 64'd0);
    chk("sb valid E3", 64'(w2.wordValid), 64'd0);
    tick();
    chk("sb busy E4", 64'(busy2), 64'd0);

    // empty mask start
    selMask = 8'h00; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    chk("zero done", 64'(done2), 64'd1);
    chk("zero busy", 64'(busy2), 64'd0);
    chk("zero rf", 64'(rf2), 64'd0);
    chk("zero valid", 64'(w2.wordValid), 64'd0);
    tick();
    chk("zero done after", 64'(done2), 64'd0);
    chk("zero busy after", 64'(busy2), 64'd0);

    // pending word survives idle and a following start
    w2.wordReady = 1'b0; EBUS = 36'h5; selMask = 8'h01; start2 = 1'b1;
    tick();
    start2 = 1'b0; selMask = 8'h00;
    tick(); tick();
    chk("keep done", 64'(done2), 64'd1);
    tick(); tick();
    chk("keep idle valid", 64'(w2.wordValid), 64'd1);
    chk("keep idle data", 64'(w2.wordData), 64'h5);
    EBUS = 36'h7; selMask = 8'h02; start2 = 1'b1;
    tick();  // E0
    start2 = 1'b0; selMask = 8'h00;
    chk("keep start busy", 64'(busy2), 64'd1);
    chk("keep start sel", 64'(w2.wordSel), 64'd0);
    tick(); tick();  // E2, slot full
    chk("keep wait busy", 64'(busy2), 64'd1);
    chk("keep wait data", 64'(w2.wordData), 64'h5);
    w2.wordReady = 1'b1;
    tick();  // E3
    chk("keep cap sel", 64'(w2.wordSel), 64'd1);
    chk("keep cap data", 64'(w2.wordData), 64'h7);
    chk("keep cap done", 64'(done2), 64'd1);
    tick();
    chk("keep drained", 64'(w2.wordValid), 64'd0);

    // Reset mid-snapshot
    EBUS = 36'h5; selMask = 8'hFF; start2 = 1'b1;
    tick();  // E0
    start2 = 1'b0; selMask = 8'h00;
    tick(); tick(); tick();  // E3
    chk("rst pre busy", 64'(busy2), 64'd1);
    resetN = 1'b0;
    #1;
    chk_u2_zero("rst mid");
    @(negedge clk) resetN = 1'b1;
    tick(); tick();
    chk("rst after busy", 64'(busy2), 64'd0);
    chk("rst after rf", 64'(rf2), 64'd0);
    chk("rst after done", 64'(done2), 64'd0);
    chk("rst after valid", 64'(w2.wordValid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/edp_diag_snap.md
# edp_diag_snap

Diagnostic snapshot sequencer sitting directly downstream of the EBox data path's diagnostic EBUS mux. On a front-end request it walks a mask of the eight EDP diagnostic sources (AR, BR, MQ, FM, BRX, ARX, ADX, AD), drives the data path's diag select and read-function enable, waits a settle interval, then captures each 36-bit EBUS word with odd parity into a single-entry valid/ready output register for the front end.

## Interface
- SETTLE, 2, cycles each select is held before EBUS is sampled; legal 1..15
- clk  in  1  system clock, all state on rising edge
- resetN  in  1  asynchronous active-low reset
- start  in  1  begin a snapshot; sampled only when busy=0
- selMask  in  8  bit i set = capture diag source i (0 AR, 1 BR, 2 MQ, 3 FM, 4 BRX, 5 ARX, 6 ADX, 7 AD); sampled with start
- abort  in  1  terminate any snapshot in progress
- EBUS  in  36  bit 0 = MSB, from data path diag mux
- diagSel  out  3  drives data path diag[4:6]
- diagReadFunc12X  out  1  enables data path EBUS drive
- busy  out  1  snapshot in progress
- wordValid  out  1  wordData/wordSel/wordParity valid
- wordReady  in  1  front end accepts word
- wordData  out  36  captured EBUS word
- wordSel  out  3  source index of wordData
- wordParity  out  1  odd parity: wordParity = ~^wordData
- done  out  1  one-cycle pulse at end of a completed (non-aborted) snapshot

## Operation
- States: IDLE, SETTLE, WAIT.
- IDLE: busy=0, diagReadFunc12X=0. On start & ~abort: latch selMask into pending mask. If mask==0: done=1 for one cycle, stay IDLE. Else → SETTLE, diagSel = lowest set index, diagReadFunc12X=1, counter=SETTLE-1.
- SETTLE: counter decrements each cycle. When counter==0 at an edge: if output slot free (~wordValid, or wordValid & wordReady same edge) capture: wordData<=EBUS, wordSel<=diagSel, wordParity<=~^EBUS, wordValid<=1, clear that mask bit; else → WAIT holding diagSel.
- WAIT: capture on first edge where slot is free, same rules as above.
- After capture: if remaining mask non-zero, diagSel = next lowest set index, counter=SETTLE-1, stay/return SETTLE; else → IDLE, diagReadFunc12X=0, busy=0, done=1 for one cycle.
- Sources captured strictly ascending index; each set bit produces exactly one word.
- Output slot: wordValid clears at edge with wordReady & ~capture; capture and drain on same edge leave wordValid=1 with new data. Pending word survives return to IDLE and a following start.
- start while busy: ignored. selMask changes while busy: ignored.
- abort (any state, higher priority than start and capture): next edge → IDLE, diagReadFunc12X=0, busy=0, wordValid=0, no done, mask cleared.
- Reset (asynchronous, any time incl. mid-snapshot): state IDLE; all outputs 0 (diagSel=0, diagReadFunc12X=0, busy=0, wordValid=0, wordData=0, wordSel=0, wordParity=0, done=0); counter and mask 0.

## Timing
- start sampled at edge E0; after E0 busy=1, diagReadFunc12X=1, diagSel valid.
- First capture at edge E0+SETTLE with free slot; wordValid high after that edge.
- Free-flowing (wordReady held 1): k-th word captured at E0+k·SETTLE; last capture edge also drops busy/diagReadFunc12X and raises done for one cycle.
- Each backpressure cycle delays that capture and all later ones by one cycle.
- EBUS must be stable from SETTLE-1 cycles after diagSel change through the capture edge; block adds no EBUS synchronisation.
- mask==0 start: done pulse after E0, busy never asserted.

## Test plan
- Reset mid-snapshot (SETTLE=2, mask 8'hFF, reset low at E3) -> all outputs 0 immediately, IDLE after release, no done.
- SETTLE=2, mask 8'h01, EBUS=36'h123456789, wordReady=1 -> diagSel=0 after E0, capture at E2: wordData=36'h123456789, wordSel=0, wordParity=0 (odd ones count → ~^=0), done pulse after E2.
- SETTLE=1, mask 8'hA5, EBUS = source index replicated, wordReady=1 -> words in order wordSel 0,2,5,7 at E1..E4, done after E4.
- Backpressure: SETTLE=2, mask 8'h03, wordReady=0 until E6 -> word0 at E2, diagSel=1 held in WAIT, word1 captured at E6 with same-edge drain, done after E6.
- abort at E3 during mask 8'hFF, SETTLE=3 -> after E3 busy=0, diagReadFunc12X=0, wordValid=0, no done; simultaneous start+abort in IDLE -> no activity.
- start while busy and mask 8'h00 start -> first ignored (word count unchanged); second yields done pulse after E0, no words, busy stays 0.
